mem_arbiter: RTL

//  Owns the single byte-wide RAM/IO port and shares it between the instruction cache and the LSB.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide memory port arbiter.
// Holds the FSM state encoding, the grant owner encoding, the length codes and the IO region tag.
package mem_arbiter_pkg;

    localparam int AddrWidth  = 32;
    localparam int InstrWidth = 32;
    localparam int ByteWidth  = 8;

    localparam logic [1:0] LEN_1B    = 2'd0;
    localparam logic [1:0] LEN_2B    = 2'd1;
    localparam logic [1:0] LEN_ILL   = 2'd2;
    localparam logic [1:0] LEN_4B    = 2'd3;
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_IOWAIT = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_ICACHE = 1'b0,
        GRANT_LSB    = 1'b1
    } grant_e;

    // The illegal 3-byte code is widened to a full word access.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:          return 3'd1;
            LEN_2B:          return 3'd2;
            LEN_ILL, LEN_4B: return 3'd4;
            default:         return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM/IO port between the icache and the LSB.
// Splits each access into per-byte RAM cycles, reassembles reads and pulses done to the owner.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int         ADDR_WIDTH = AddrWidth,
    parameter int         DATA_WIDTH = InstrWidth,
    parameter logic [1:0] IO_BASE_HI = IO_REGION
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  icache_req_in,
    input  logic [ADDR_WIDTH-1:0] icache_addr_in,
    output logic                  mc_to_icache_en_out,
    output logic [DATA_WIDTH-1:0] mc_icache_data_out,
    input  logic                  lsb_req_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_len_in,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
    input  logic [DATA_WIDTH-1:0] lsb_wdata_in,
    output logic                  mc_to_lsb_en_out,
    output logic [DATA_WIDTH-1:0] mc_lsb_data_out,
    input  logic                  clear_branch_in,
    input  logic                  io_buffer_full_in,
    input  logic [ByteWidth-1:0]  mem_din_in,
    output logic [ByteWidth-1:0]  mem_dout_out,
    output logic [ADDR_WIDTH-1:0] mem_a_out,
    output logic                  mem_wr_out
);

    arb_state_e             state_r, state_nxt_s;
    grant_e                 last_grant_r, last_grant_nxt_s;
    logic [ADDR_WIDTH-1:0]  base_r, base_nxt_s;
    logic [2:0]             len_r, len_nxt_s;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_nxt_s;
    logic                   io_r, io_nxt_s;
    logic [2:0]             cnt_r, cnt_nxt_s;
    logic                   cur_v_r, cur_v_nxt_s;
    logic [1:0]             cur_lane_r, cur_lane_nxt_s;
    logic                   pend_v_r, pend_v_nxt_s;
    logic [1:0]             pend_lane_r, pend_lane_nxt_s;
    logic                   cap_done_r, cap_done_nxt_s;
    logic [DATA_WIDTH-1:0]  buf_r, buf_nxt_s;
    logic [ADDR_WIDTH-1:0]  mem_a_r, mem_a_nxt_s;
    logic [ByteWidth-1:0]   mem_dout_r, mem_dout_nxt_s;
    logic                   mem_wr_r, mem_wr_nxt_s;
    logic                   ic_en_r, ic_en_nxt_s;
    logic [DATA_WIDTH-1:0]  ic_data_r, ic_data_nxt_s;
    logic                   lsb_en_r, lsb_en_nxt_s;
    logic [DATA_WIDTH-1:0]  lsb_data_r, lsb_data_nxt_s;

    logic                   take_lsb_s;
    logic                   take_ic_s;
    logic                   adv_s;
    logic                   ic_abort_s;

    // Two-way round robin: on a tie the requester that did not win last time is served.
    always_comb begin
        take_lsb_s = 1'b0;
        take_ic_s  = 1'b0;
        if (lsb_req_in && (!icache_req_in || last_grant_r == GRANT_ICACHE || clear_branch_in)) begin
            take_lsb_s = 1'b1;
        end else if (icache_req_in && !clear_branch_in) begin
            take_ic_s = 1'b1;
        end else begin
            take_lsb_s = 1'b0;
            take_ic_s  = 1'b0;
        end
    end

    // A branch flush aborts an icache access even while rdy_in is low.
    assign ic_abort_s = clear_branch_in && (last_grant_r == GRANT_ICACHE) &&
                        (state_r == ST_READ || state_r == ST_DONE);
    assign adv_s      = rdy_in || ic_abort_s;

    // Next-state, byte sequencing, read-byte capture and done-pulse generation.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        base_nxt_s       = base_r;
        len_nxt_s        = len_r;
        wdata_nxt_s      = wdata_r;
        io_nxt_s         = io_r;
        cnt_nxt_s        = cnt_r;
        cur_v_nxt_s      = 1'b0;
        cur_lane_nxt_s   = cur_lane_r;
        pend_v_nxt_s     = cur_v_r;
        pend_lane_nxt_s  = cur_lane_r;
        cap_done_nxt_s   = 1'b0;
        buf_nxt_s        = buf_r;
        mem_a_nxt_s      = mem_a_r;
        mem_dout_nxt_s   = mem_dout_r;
        mem_wr_nxt_s     = 1'b0;
        ic_en_nxt_s      = 1'b0;
        ic_data_nxt_s    = ic_data_r;
        lsb_en_nxt_s     = 1'b0;
        lsb_data_nxt_s   = lsb_data_r;

        // mem_din_in carries the byte for the address driven two edges back.
        if (pend_v_r) begin
            buf_nxt_s[{pend_lane_r, 3'b000} +: ByteWidth] = mem_din_in;
            cap_done_nxt_s = ({1'b0, pend_lane_r} == (len_r - 3'd1));
        end else begin
            cap_done_nxt_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 3'd0;
                if (take_lsb_s) begin
                    last_grant_nxt_s = GRANT_LSB;
                    base_nxt_s       = lsb_addr_in;
                    len_nxt_s        = len_to_bytes(lsb_len_in);
                    wdata_nxt_s      = lsb_wdata_in;
                    io_nxt_s         = (lsb_addr_in[17:16] == IO_BASE_HI);
                    buf_nxt_s        = '0;
                    mem_a_nxt_s      = lsb_addr_in;
                    if (lsb_wr_in) begin
                        if ((lsb_addr_in[17:16] == IO_BASE_HI) && io_buffer_full_in) begin
                            state_nxt_s = ST_IOWAIT;
                        end else begin
                            state_nxt_s    = ST_WRITE;
                            mem_dout_nxt_s = lsb_wdata_in[ByteWidth-1:0];
                            mem_wr_nxt_s   = 1'b1;
                            cnt_nxt_s      = 3'd1;
                        end
                    end else begin
                        state_nxt_s    = ST_READ;
                        cur_v_nxt_s    = 1'b1;
                        cur_lane_nxt_s = 2'd0;
                        cnt_nxt_s      = 3'd1;
                    end
                end else if (take_ic_s) begin
                    last_grant_nxt_s = GRANT_ICACHE;
                    base_nxt_s       = icache_addr_in;
                    len_nxt_s        = 3'd4;
                    io_nxt_s         = 1'b0;
                    buf_nxt_s        = '0;
                    mem_a_nxt_s      = icache_addr_in;
                    state_nxt_s      = ST_READ;
                    cur_v_nxt_s      = 1'b1;
                    cur_lane_nxt_s   = 2'd0;
                    cnt_nxt_s        = 3'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (ic_abort_s) begin
                    state_nxt_s  = ST_IDLE;
                    pend_v_nxt_s = 1'b0;
                end else if (cap_done_r) begin
                    state_nxt_s = ST_DONE;
                    if (last_grant_r == GRANT_ICACHE) begin
                        ic_en_nxt_s   = 1'b1;
                        ic_data_nxt_s = buf_r;
                    end else begin
                        lsb_en_nxt_s   = 1'b1;
                        lsb_data_nxt_s = buf_r;
                    end
                end else if (cnt_r < len_r) begin
                    mem_a_nxt_s    = base_r + ADDR_WIDTH'(cnt_r);
                    cur_v_nxt_s    = 1'b1;
                    cur_lane_nxt_s = cnt_r[1:0];
                    cnt_nxt_s      = cnt_r + 3'd1;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_WRITE, ST_IOWAIT: begin
                if (cnt_r >= len_r) begin
                    state_nxt_s  = ST_DONE;
                    lsb_en_nxt_s = 1'b1;
                end else if (io_r && io_buffer_full_in) begin
                    state_nxt_s = ST_IOWAIT;
                end else begin
                    state_nxt_s    = ST_WRITE;
                    mem_a_nxt_s    = base_r + ADDR_WIDTH'(cnt_r);
                    mem_dout_nxt_s = wdata_r[{cnt_r[1:0], 3'b000} +: ByteWidth];
                    mem_wr_nxt_s   = 1'b1;
                    cnt_nxt_s      = cnt_r + 3'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; everything freezes while the port is not advancing.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_ICACHE;
            base_r       <= '0;
            len_r        <= 3'd0;
            wdata_r      <= '0;
            io_r         <= 1'b0;
            cnt_r        <= 3'd0;
            cur_v_r      <= 1'b0;
            cur_lane_r   <= 2'd0;
            pend_v_r     <= 1'b0;
            pend_lane_r  <= 2'd0;
            cap_done_r   <= 1'b0;
            buf_r        <= '0;
            mem_a_r      <= '0;
            mem_dout_r   <= '0;
            mem_wr_r     <= 1'b0;
            ic_en_r      <= 1'b0;
            ic_data_r    <= '0;
            lsb_en_r     <= 1'b0;
            lsb_data_r   <= '0;
        end else if (adv_s) begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            base_r       <= base_nxt_s;
            len_r        <= len_nxt_s;
            wdata_r      <= wdata_nxt_s;
            io_r         <= io_nxt_s;
            cnt_r        <= cnt_nxt_s;
            cur_v_r      <= cur_v_nxt_s;
            cur_lane_r   <= cur_lane_nxt_s;
            pend_v_r     <= pend_v_nxt_s;
            pend_lane_r  <= pend_lane_nxt_s;
            cap_done_r   <= cap_done_nxt_s;
            buf_r        <= buf_nxt_s;
            mem_a_r      <= mem_a_nxt_s;
            mem_dout_r   <= mem_dout_nxt_s;
            mem_wr_r     <= mem_wr_nxt_s;
            ic_en_r      <= ic_en_nxt_s;
            ic_data_r    <= ic_data_nxt_s;
            lsb_en_r     <= lsb_en_nxt_s;
            lsb_data_r   <= lsb_data_nxt_s;
        end
    end

    assign mem_wr_out          = mem_wr_r & rdy_in;
    assign mem_a_out           = mem_a_r;
    assign mem_dout_out        = mem_dout_r;
    assign mc_to_icache_en_out = ic_en_r;
    assign mc_icache_data_out  = ic_data_r;
    assign mc_to_lsb_en_out    = lsb_en_r;
    assign mc_lsb_data_out     = lsb_data_r;

endmodule
